// File: rtl/ws_systolic_mmu.sv
// Weight-stationary SIZE x SIZE systolic multiply-accumulate array.
// Define MMU_SAT_ACC_EN to make every PE addition saturate instead of wrapping.
module ws_systolic_mmu #(
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 16,
    parameter int SIZE      = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                control,
    input  logic [BIT_WIDTH*SIZE-1:0]           wt_arr,
    input  logic [BIT_WIDTH*SIZE-1:0]           data_arr,
    output logic [ACC_WIDTH*SIZE*(SIZE+1)-1:0]  acc_out,
    output logic [ACC_WIDTH*SIZE-1:0]           acc_out_final
);

    // Product width wide enough for both the full product and the accumulator.
    localparam int PW = (2*BIT_WIDTH > ACC_WIDTH) ? 2*BIT_WIDTH : ACC_WIDTH;

    logic [BIT_WIDTH-1:0] w_r   [SIZE][SIZE];
    logic [BIT_WIDTH-1:0] d_r   [SIZE][SIZE];
    logic [ACC_WIDTH-1:0] p_r   [SIZE][SIZE];
    logic [BIT_WIDTH-1:0] w_in_s[SIZE][SIZE];
    logic [BIT_WIDTH-1:0] x_s   [SIZE][SIZE];
    logic [ACC_WIDTH-1:0] pin_s [SIZE][SIZE];
    logic [ACC_WIDTH-1:0] sum_s [SIZE][SIZE];

    function automatic logic [ACC_WIDTH-1:0] mac(
        input logic [ACC_WIDTH-1:0] pin,
        input logic [BIT_WIDTH-1:0] x,
        input logic [BIT_WIDTH-1:0] w
    );
        logic [PW-1:0]      prod;
        logic [ACC_WIDTH:0] sum;
        prod = PW'(x) * PW'(w);
        sum  = {1'b0, pin} + {1'b0, prod[ACC_WIDTH-1:0]};
`ifdef MMU_SAT_ACC_EN
        if (sum[ACC_WIDTH]) begin
            mac = {ACC_WIDTH{1'b1}};
        end else begin
            mac = sum[ACC_WIDTH-1:0];
        end
`else
        mac = sum[ACC_WIDTH-1:0];
`endif
    endfunction

    genvar gr, gc;
    generate
        for (gr = 0; gr < SIZE; gr++) begin : g_row
            for (gc = 0; gc < SIZE; gc++) begin : g_col
                // Row 0 takes the new weight word; lower rows take the row above.
                if (gr == 0) begin : g_top
                    assign w_in_s[gr][gc] = wt_arr[gc*BIT_WIDTH +: BIT_WIDTH];
                    assign pin_s[gr][gc]  = {ACC_WIDTH{1'b0}};
                end else begin : g_inner
                    assign w_in_s[gr][gc] = w_r[gr-1][gc];
                    assign pin_s[gr][gc]  = p_r[gr-1][gc];
                end
                if (gc == 0) begin : g_left
                    assign x_s[gr][gc] = data_arr[gr*BIT_WIDTH +: BIT_WIDTH];
                end else begin : g_right
                    assign x_s[gr][gc] = d_r[gr][gc-1];
                end
                assign sum_s[gr][gc] = mac(pin_s[gr][gc], x_s[gr][gc], w_r[gr][gc]);
                assign acc_out[(gr+1)*ACC_WIDTH*SIZE + gc*ACC_WIDTH +: ACC_WIDTH] = p_r[gr][gc];
            end
        end
    endgenerate

    assign acc_out[0 +: ACC_WIDTH*SIZE] = {(ACC_WIDTH*SIZE){1'b0}};
    assign acc_out_final = acc_out[SIZE*ACC_WIDTH*SIZE +: ACC_WIDTH*SIZE];

    // PE array state: weight shift in load mode, MAC pipeline in compute mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    w_r[r][c] <= {BIT_WIDTH{1'b0}};
                    d_r[r][c] <= {BIT_WIDTH{1'b0}};
                    p_r[r][c] <= {ACC_WIDTH{1'b0}};
                end
            end
        end else if (control) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    w_r[r][c] <= w_in_s[r][c];
                    d_r[r][c] <= {BIT_WIDTH{1'b0}};
                    p_r[r][c] <= {ACC_WIDTH{1'b0}};
                end
            end
        end else begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    d_r[r][c] <= x_s[r][c];
                    p_r[r][c] <= sum_s[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_ws_systolic_mmu.sv
// Scoreboard bench for ws_systolic_mmu: directed vectors, queue-based checking.
module tb_ws_systolic_mmu;

    localparam int BW = 8;
    localparam int AW = 16;
    localparam int N  = 4;
    localparam int OW = AW*N*(N+1);

    logic                clk;
    logic                reset;
    logic                control;
    logic [BW*N-1:0]     wt_arr;
    logic [BW*N-1:0]     data_arr;
    logic [OW-1:0]       acc_out;
    logic [AW*N-1:0]     acc_out_final;

    ws_systolic_mmu #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .SIZE(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .control       (control),
        .wt_arr        (wt_arr),
        .data_arr      (data_arr),
        .acc_out       (acc_out),
        .acc_out_final (acc_out_final)
    );

    typedef struct {
        int            at;
        int            sel;
        logic [OW-1:0] vec;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   edges = 0;
    int   total = 0;
    int   bad   = 0;
    event chk_now;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic expect_col(input int at, input int c, input logic [AW-1:0] v, input string nm);
        exp_t e;
        e.at = at; e.sel = c; e.vec = '0; e.vec[AW-1:0] = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expect_vec(input int at, input logic [OW-1:0] v, input string nm);
        exp_t e;
        e.at = at; e.sel = -1; e.vec = v; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation whose time has come.
    initial begin : monitor
        exp_t          e;
        logic [AW-1:0] got;
        forever begin
            @(negedge clk or chk_now);
            while (sb.size() > 0 && sb[0].at <= edges) begin
                e = sb.pop_front();
                total++;
                if (e.sel < 0) begin
                    if (acc_out !== e.vec) begin
                        bad++;
                        $display("FAIL %s got=%h want=%h", e.name, acc_out, e.vec);
                    end
                end else begin
                    got = acc_out_final[e.sel*AW +: AW];
                    if (got !== e.vec[AW-1:0]) begin
                        bad++;
                        $display("FAIL %s got=%h want=%h", e.name, got, e.vec[AW-1:0]);
                    end
                end
            end
        end
    end

    task automatic step(input logic ctl, input logic [BW*N-1:0] wt, input logic [BW*N-1:0] dat);
        control  = ctl;
        wt_arr   = wt;
        data_arr = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
        step(1'b1, w0, 32'h0);
        step(1'b1, w1, 32'h0);
        step(1'b1, w2, 32'h0);
        step(1'b1, w3, 32'h0);
    endtask

    initial begin : stim
        int            base;
        logic [OW-1:0] v;
        logic [AW-1:0] ovf;
        logic [31:0]   ex_data [7];

        reset = 1'b0; control = 1'b0; wt_arr = '0; data_arr = '0;
        #3;
        expect_vec(-1, '0, "reset_init");
        -> chk_now;
        @(posedge clk); #1;
        reset = 1'b1;

        // Asynchronous reset in the middle of a compute stream.
        load4(32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403);
        step(1'b0, 32'h0, 32'h01010101);
        step(1'b0, 32'h0, 32'h01010101);
        #1 reset = 1'b0;
        #1;
        expect_vec(-1, '0, "async_reset");
        -> chk_now;
        #1 reset = 1'b1;
        base = edges;
        expect_vec(base + 4, '0, "post_rst_e3");
        expect_vec(base + 8, '0, "post_rst_e7");
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h01010101);

        // Worked example, vectors 0..2.
        load4(32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403);
        ex_data = '{32'h00000001, 32'h00000102, 32'h00010200, 32'h00010100,
                    32'h02030200, 32'h04010000, 32'h05000000};
        base = edges;
        v = '0;
        v[AW*N +: AW] = 16'd3;
        expect_vec(base + 1, v, "interm_e0");
        expect_col(base + 4, 0, 16'd8,  "ex_v0_c0");
        expect_col(base + 5, 0, 16'd21, "ex_v1_c0");
        expect_col(base + 5, 1, 16'd7,  "ex_v0_c1");
        expect_col(base + 6, 2, 16'd7,  "ex_v0_c2");
        expect_col(base + 6, 0, 16'd27, "ex_v2_c0");
        expect_col(base + 7, 3, 16'd11, "ex_v0_c3");
        expect_col(base + 8, 3, 16'd29, "ex_v1_c3");
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0, ex_data[i]);
        step(1'b0, 32'h0, 32'h0);

        // Identity weights pass the vector straight through.
        load4(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
        base = edges;
        expect_col(base + 4, 0, 16'd5, "id_c0");
        expect_col(base + 5, 1, 16'd6, "id_c1");
        expect_col(base + 6, 2, 16'd7, "id_c2");
        expect_col(base + 7, 3, 16'd8, "id_c3");
        step(1'b0, 32'h0, 32'h00000005);
        step(1'b0, 32'h0, 32'h00000600);
        step(1'b0, 32'h0, 32'h00070000);
        step(1'b0, 32'h0, 32'h08000000);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0);

        // Overflow: four FF*FF products accumulated in one column.
`ifdef MMU_SAT_ACC_EN
        ovf = 16'hFFFF;
`else
        ovf = 16'hF804;
`endif
        load4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        base = edges;
        expect_col(base + 4, 0, ovf, "ovf_c0");
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'hFFFFFFFF);

        // Mode switch mid-stream clears psums and shifts weights one row.
        load4(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h01010101);
        expect_vec(edges + 1, '0, "mode_switch_zero");
        step(1'b1, 32'h00000002, 32'h0);
        base = edges;
        expect_col(base + 4, 0, 16'd10, "sw_c0");
        expect_col(base + 5, 1, 16'd5,  "sw_c1");
        expect_col(base + 6, 2, 16'd6,  "sw_c2");
        expect_col(base + 7, 3, 16'd0,  "sw_c3");
        step(1'b0, 32'h0, 32'h00000003);
        step(1'b0, 32'h0, 32'h00000400);
        step(1'b0, 32'h0, 32'h00050000);
        step(1'b0, 32'h0, 32'h06000000);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws_systolic_mmu.md
Name: ws_systolic_mmu

Overview:
- Weight-stationary systolic matrix-multiply unit: a SIZE x SIZE grid of multiply-accumulate processing elements (PEs).
- Weight rows are preloaded through a vertical shift chain. Activations then stream in from the left edge, one row lane per array row, pre-skewed by the caller.
- Partial sums flow downward; column results exit at the bottom row.
- Sits between the activation/weight buffers and the accumulator stage of the accelerator datapath.

Parameters:
- BIT_WIDTH, 8, width of each unsigned data and weight element.
- ACC_WIDTH, 16, width of each partial sum and result element.
- SIZE, 4, array dimension (rows = columns = SIZE).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- control  input  1  1 = weight-load mode, 0 = compute mode.
- wt_arr  input  BIT_WIDTH*SIZE  one weight row; column c at [c*BIT_WIDTH +: BIT_WIDTH].
- data_arr  input  BIT_WIDTH*SIZE  activation lanes; lane r (into array row r) at [r*BIT_WIDTH +: BIT_WIDTH].
- acc_out  output  ACC_WIDTH*SIZE*(SIZE+1)  all partial-sum rows.
  - Slice j at [j*ACC_WIDTH*SIZE +: ACC_WIDTH*SIZE].
  - Slice 0 is constant zero (row-0 psum input).
  - Slice r+1 is the psum register row of array row r.
  - Column c within a slice at [c*ACC_WIDTH +: ACC_WIDTH].
- acc_out_final  output  ACC_WIDTH*SIZE  equals slice SIZE of acc_out (bottom-row psums).

Behaviour:
- Reset (reset=0, asynchronous): all weight, data and psum registers cleared to 0. acc_out and acc_out_final read 0. Applies mid-load or mid-compute; operation resumes on the first rising edge after release.
- Per PE(r,c) state: weight w, data register d, psum register p. All math is unsigned.
- Weight load (control=1), each edge:
  - Row 0 weights <= wt_arr.
  - Row r weights <= row r-1 weights.
  - After SIZE load edges, row SIZE-1 holds the first word loaded and row 0 holds the last.
  - All d and p registers load 0 during load edges.
- Compute (control=0): weights hold. Each edge:
  - d(r,0) <= data_arr lane r.
  - d(r,c) <= d(r,c-1).
  - p(r,c) <= pin + x*w(r,c), where x is the data entering the PE this edge (data_arr lane r for c=0, else d(r,c-1)).
  - pin = 0 for r=0, else p(r-1,c).
- Arithmetic:
  - Product is 2*BIT_WIDTH bits, zero-extended or truncated to ACC_WIDTH.
  - Sum wraps modulo 2^ACC_WIDTH.
- Skew contract (caller responsibility):
  - Vector k element r is presented on lane r at compute edge k+r (edges numbered from 0).
  - Result column c of vector k is visible on acc_out_final after edge k+c+SIZE-1.
  - Result = sum over r of x_k[r]*w(r,c).
- Data leaving the last column is discarded. No valid/ready handshake; outputs are direct register views with no extra latency.
- A control 0->1 transition mid-stream zeroes the datapath on that edge; in-flight results are lost.

Optional Feature:
- Macro MMU_SAT_ACC_EN.
- Defined: each PE addition saturates to 2^ACC_WIDTH-1 instead of wrapping.
- Undefined: modulo-2^ACC_WIDTH wrap.

Test Plan:
- Reset: drive nonzero weights and data, pull reset=0 asynchronously mid-compute.
  - All of acc_out reads 0 immediately.
  - After release, with control=0 and data_arr=32'h01010101, outputs stay 0 (weights cleared).
- Example (SIZE=4):
  - Load wt_arr 05020304, 03010203, 07040102, 01020403 on 4 edges (control=1).
  - Then stream data_arr 00000001, 00000102, 00010200, 00010100, 02030200, 04010000, 05000000.
  - Expect acc_out_final column 0 = 8 after edge 3, column 1 = 7 after edge 4, column 2 = 7 after edge 5, column 3 = 11 after edge 6.
- Identity:
  - Load 01000000, 00010000, 00000100, 00000001.
  - Stream skewed vector (5,6,7,8).
  - Expect columns 0..3 = 5, 6, 7, 8 after edges 3, 4, 5, 6 respectively.
- Overflow: all weights FF; all lanes FF, skewed.
  - Column 0 after edge 3 = 16'hF804 (wrap).
  - With MMU_SAT_ACC_EN: 16'hFFFF.
- Mode switch: raise control=1 mid-compute.
  - On that edge all acc_out psum slices become 0.
  - Weights shift down one row.
- Intermediate slices: after edge 0 of the example, acc_out slice 1 column 0 = 1*3 = 3.
  - All other PEs still 0 except row-0 column 0.
